// File: rtl/mem_byte_stage_if.sv
// Bundle for the memory-access stage: execute-stage request, byte-wide RAM port
// and the registered write-back result.
interface mem_byte_stage_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid_i;
  logic [2:0]        read_i;
  logic [1:0]        write_i;
  logic [4:0]        wd_i;
  logic              wreg_i;
  logic [31:0]       addr_i;
  logic [31:0]       wdata_i;
  logic              stall_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_wr_o;
  logic [7:0]        mem_dout_o;
  logic [7:0]        mem_din_i;
  logic              wb_valid_o;
  logic [4:0]        wd_o;
  logic              wreg_o;
  logic [31:0]       wdata_o;

  // The stage itself.
  modport slave (
    input  req_valid_i, read_i, write_i, wd_i, wreg_i, addr_i, wdata_i, mem_din_i,
    output stall_o, mem_addr_o, mem_wr_o, mem_dout_o, wb_valid_o, wd_o, wreg_o, wdata_o
  );

  // The surrounding pipeline and RAM.
  modport master (
    output req_valid_i, read_i, write_i, wd_i, wreg_i, addr_i, wdata_i, mem_din_i,
    input  stall_o, mem_addr_o, mem_wr_o, mem_dout_o, wb_valid_o, wd_o, wreg_o, wdata_o
  );
endinterface

// File: rtl/mem_byte_stage.sv
// Memory-access stage: byte-serial little-endian loads/stores over a synchronous
// byte RAM, stalling upstream while a multi-byte access is in flight.
module mem_byte_stage #(
  parameter int ADDR_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_byte_stage_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_RTAIL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  function automatic logic [7:0] byte_lane(input logic [31:0] w, input logic [1:0] idx);
    return w[{idx, 3'b000} +: 8];
  endfunction

  function automatic logic [1:0] last_index(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 2'd0;
      SZ_H:    return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] w, input logic [1:0] sz,
                                              input logic sgn);
    case (sz)
      SZ_B:    return {{24{sgn & w[7]}}, w[7:0]};
      SZ_H:    return {{16{sgn & w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  state_t            state_r, state_s;
  logic [1:0]        k_r;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       wdata_r;
  logic [31:0]       data_r;
  logic              store_r;
  logic              signed_r;
  logic [1:0]        size_r;
  logic [4:0]        wd_r;
  logic              wreg_r;
  logic              rd_pend_r;
  logic [1:0]        rd_lane_r;

  logic              is_store_s;
  logic              is_load_s;
  logic              mem_op_s;
  logic [1:0]        size_s;
  logic              signed_s;
  logic              accept_s;
  logic              last_s;
  logic [1:0]        k_next_s;
  logic [31:0]       data_cur_s;
  logic              stall_s;

  logic [ADDR_W-1:0] mem_addr_r, mem_addr_s;
  logic              mem_wr_r, mem_wr_s;
  logic [7:0]        mem_dout_r, mem_dout_s;
  logic              wb_valid_r, wb_valid_s;
  logic [4:0]        wd_o_r, wd_o_s;
  logic              wreg_o_r, wreg_o_s;
  logic [31:0]       wdata_o_r, wdata_o_s;

  // Decode the incoming request; stores win over loads.
  always_comb begin
    is_store_s = (bus.write_i != 2'b00);
    is_load_s  = 1'b0;
    size_s     = SZ_B;
    signed_s   = 1'b0;
    if (is_store_s) begin
      case (bus.write_i)
        2'b01:   size_s = SZ_B;
        2'b10:   size_s = SZ_H;
        default: size_s = SZ_W;
      endcase
    end else begin
      case (bus.read_i)
        3'b001: begin is_load_s = 1'b1; size_s = SZ_B; signed_s = 1'b1; end
        3'b010: begin is_load_s = 1'b1; size_s = SZ_H; signed_s = 1'b1; end
        3'b011: begin is_load_s = 1'b1; size_s = SZ_W; end
        3'b100: begin is_load_s = 1'b1; size_s = SZ_B; end
        3'b101: begin is_load_s = 1'b1; size_s = SZ_H; end
        default: is_load_s = 1'b0;
      endcase
    end
    mem_op_s = is_store_s | is_load_s;
    accept_s = (state_r == ST_IDLE) & bus.req_valid_i & mem_op_s;
    last_s   = (k_r == last_index(size_r));
    k_next_s = k_r + 2'd1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_XFER;
        else          state_s = ST_IDLE;
      end
      ST_XFER: begin
        if (last_s) state_s = store_r ? ST_DONE : ST_RTAIL;
        else        state_s = ST_XFER;
      end
      ST_RTAIL: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Output logic: combinational stall plus next values for the registered outputs.
  always_comb begin
    stall_s    = (accept_s | (state_r == ST_XFER) | (state_r == ST_RTAIL)) & rst_n;
    data_cur_s = data_r;
    if (rd_pend_r) data_cur_s[{rd_lane_r, 3'b000} +: 8] = bus.mem_din_i;
    else           data_cur_s = data_r;
    mem_addr_s = '0;
    mem_wr_s   = 1'b0;
    mem_dout_s = 8'h00;
    wb_valid_s = 1'b0;
    wd_o_s     = 5'd0;
    wreg_o_s   = 1'b0;
    wdata_o_s  = 32'h0000_0000;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          mem_addr_s = bus.addr_i[ADDR_W-1:0];
          mem_wr_s   = is_store_s;
          mem_dout_s = is_store_s ? bus.wdata_i[7:0] : 8'h00;
        end else if (bus.req_valid_i) begin
          wb_valid_s = 1'b1;
          wd_o_s     = bus.wd_i;
          wreg_o_s   = bus.wreg_i;
          wdata_o_s  = bus.wdata_i;
        end else begin
          wb_valid_s = 1'b0;
        end
      end
      ST_XFER: begin
        if (!last_s) begin
          mem_addr_s = addr_r + ADDR_W'(k_next_s);
          mem_wr_s   = store_r;
          mem_dout_s = store_r ? byte_lane(wdata_r, k_next_s) : 8'h00;
        end else if (store_r) begin
          wb_valid_s = 1'b1;
          wd_o_s     = wd_r;
        end else begin
          wb_valid_s = 1'b0;
        end
      end
      ST_RTAIL: begin
        // Last byte is still on mem_din_i, so extend the merged word.
        wb_valid_s = 1'b1;
        wd_o_s     = wd_r;
        wreg_o_s   = wreg_r;
        wdata_o_s  = load_extend(data_cur_s, size_r, signed_r);
      end
      ST_DONE: wb_valid_s = 1'b0;
      default: wb_valid_s = 1'b0;
    endcase
  end

  // Request latch, byte counter and load-lane assembly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_r       <= 2'd0;
      addr_r    <= '0;
      wdata_r   <= 32'h0000_0000;
      data_r    <= 32'h0000_0000;
      store_r   <= 1'b0;
      signed_r  <= 1'b0;
      size_r    <= SZ_B;
      wd_r      <= 5'd0;
      wreg_r    <= 1'b0;
      rd_pend_r <= 1'b0;
      rd_lane_r <= 2'd0;
    end else begin
      if (accept_s) begin
        k_r      <= 2'd0;
        addr_r   <= bus.addr_i[ADDR_W-1:0];
        wdata_r  <= bus.wdata_i;
        data_r   <= 32'h0000_0000;
        store_r  <= is_store_s;
        signed_r <= signed_s;
        size_r   <= size_s;
        wd_r     <= bus.wd_i;
        wreg_r   <= bus.wreg_i;
      end else begin
        if (state_r == ST_XFER) k_r <= k_next_s;
        if (rd_pend_r) data_r[{rd_lane_r, 3'b000} +: 8] <= bus.mem_din_i;
      end
      // Byte requested in XFER(k) returns next cycle into lane k.
      rd_pend_r <= (state_r == ST_XFER) & ~store_r;
      rd_lane_r <= k_r;
    end
  end

  // Registered RAM-port and write-back outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_r <= '0;
      mem_wr_r   <= 1'b0;
      mem_dout_r <= 8'h00;
      wb_valid_r <= 1'b0;
      wd_o_r     <= 5'd0;
      wreg_o_r   <= 1'b0;
      wdata_o_r  <= 32'h0000_0000;
    end else begin
      mem_addr_r <= mem_addr_s;
      mem_wr_r   <= mem_wr_s;
      mem_dout_r <= mem_dout_s;
      wb_valid_r <= wb_valid_s;
      wd_o_r     <= wd_o_s;
      wreg_o_r   <= wreg_o_s;
      wdata_o_r  <= wdata_o_s;
    end
  end

  assign bus.stall_o    = stall_s;
  assign bus.mem_addr_o = mem_addr_r;
  assign bus.mem_wr_o   = mem_wr_r;
  assign bus.mem_dout_o = mem_dout_r;
  assign bus.wb_valid_o = wb_valid_r;
  assign bus.wd_o       = wd_o_r;
  assign bus.wreg_o     = wreg_o_r;
  assign bus.wdata_o    = wdata_o_r;

endmodule

// File: tb/tb_mem_byte_stage.sv
// Bench for mem_byte_stage: vector table driven through a byte RAM model, with
// scoreboard queues for the RAM bus and write-back, plus a mid-access reset.
module tb_mem_byte_stage;
  localparam int          ADDR_W = 17;
  localparam logic [31:0] AMASK  = 32'h0001_FFFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_byte_stage_if #(.ADDR_W(ADDR_W)) bus ();
  mem_byte_stage #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  typedef struct {
    logic [2:0]  rd;
    logic [1:0]  wr;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    logic        exp_wreg;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] data;
  } wb_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  dout;
  } bus_exp_t;

  wb_exp_t  wb_q[$];
  bus_exp_t bus_q[$];
  int       tests = 0;
  int       fails = 0;
  int       cyc = 0;
  bit       mon_en = 1'b0;
  logic     stall_seen;
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  vec_t     vecs[16];
  vec_t     pv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    bus_exp_t be;
    wb_exp_t  we;
    if (!mon_en) return;
    if (bus_q.size() > 0 && bus_q[0].cyc == cyc) begin
      be = bus_q.pop_front();
      chk("bus_addr", 32'(bus.mem_addr_o), be.addr);
      chk("bus_wr", 32'(bus.mem_wr_o), 32'(be.wr));
      if (be.wr) chk("bus_dout", 32'(bus.mem_dout_o), 32'(be.dout));
    end else begin
      chk("bus_idle", 32'(bus.mem_addr_o) | 32'(bus.mem_dout_o) | 32'(bus.mem_wr_o), 32'd0);
    end
    if (bus.wb_valid_o) begin
      if (wb_q.size() == 0) begin
        chk("wb_unexpected", 32'(bus.wb_valid_o), 32'd0);
      end else begin
        we = wb_q.pop_front();
        chk("wb_cycle", 32'(cyc), 32'(we.cyc));
        chk("wb_wd", 32'(bus.wd_o), 32'(we.wd));
        chk("wb_wreg", 32'(bus.wreg_o), 32'(we.wreg));
        chk("wb_data", bus.wdata_o, we.data);
      end
    end else if (wb_q.size() > 0 && wb_q[0].cyc <= cyc) begin
      we = wb_q.pop_front();
      chk("wb_missing", 32'(bus.wb_valid_o), 32'd1);
    end
  endtask

  // One clock: check outputs at the falling edge, then play the RAM after the rising edge.
  task automatic tick();
    logic [ADDR_W-1:0] a;
    logic              w;
    logic [7:0]        d;
    logic [7:0]        rdat;
    @(negedge clk);
    stall_seen = bus.stall_o;
    monitor();
    a = bus.mem_addr_o;
    w = bus.mem_wr_o;
    d = bus.mem_dout_o;
    @(posedge clk);
    #1;
    cyc++;
    rdat = mem[a];
    if (w) mem[a] = d;
    bus.mem_din_i = rdat;
  endtask

  task automatic issue(input vec_t v, input string tag);
    int          c0;
    int          n;
    int          hold;
    int          lat;
    bit          st;
    bit          ld;
    logic [31:0] sh;
    st = (v.wr != 2'b00);
    ld = !st && (v.rd inside {[3'd1:3'd5]});
    n  = 0;
    if (st)      n = (v.wr == 2'b01) ? 1 : (v.wr == 2'b10) ? 2 : 4;
    else if (ld) n = (v.rd == 3'd1 || v.rd == 3'd4) ? 1 : (v.rd == 3'd3) ? 4 : 2;
    lat = st ? n + 1 : (ld ? n + 2 : 1);
    bus.read_i      = v.rd;
    bus.write_i     = v.wr;
    bus.wd_i        = v.wd;
    bus.wreg_i      = v.wreg;
    bus.addr_i      = v.addr;
    bus.wdata_i     = v.wdata;
    bus.req_valid_i = 1'b1;
    c0 = cyc;
    for (int k = 0; k < n; k++) begin
      sh = v.wdata >> (8 * k);
      bus_q.push_back('{c0 + 1 + k, (v.addr + 32'(k)) & AMASK, st, sh[7:0]});
    end
    wb_q.push_back('{c0 + lat, v.wd, v.exp_wreg, v.exp_data});
    tick();
    hold = 1;
    chk({tag, "_accept_stall"}, 32'(stall_seen), 32'(st | ld));
    while (stall_seen && hold < 12) begin
      tick();
      hold++;
    end
    chk({tag, "_hold_cycles"}, 32'(hold), 32'(st ? n + 2 : (ld ? n + 3 : 1)));
    bus.req_valid_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_stall"}, 32'(bus.stall_o), 32'd0);
    chk({tag, "_mem_wr"}, 32'(bus.mem_wr_o), 32'd0);
    chk({tag, "_wb_valid"}, 32'(bus.wb_valid_o), 32'd0);
    chk({tag, "_mem_bus"}, 32'(bus.mem_addr_o) | 32'(bus.mem_dout_o), 32'd0);
    chk({tag, "_wb_fields"}, bus.wdata_o | 32'(bus.wd_o) | 32'(bus.wreg_o), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
    bus.req_valid_i = 1'b0;
    bus.read_i      = 3'd0;
    bus.write_i     = 2'd0;
    bus.wd_i        = 5'd0;
    bus.wreg_i      = 1'b0;
    bus.addr_i      = 32'h0;
    bus.wdata_i     = 32'h0;
    bus.mem_din_i   = 8'h00;

    //         rd    wr    wd      wreg  addr          wdata          exp_data       exp_wreg
    vecs[0]  = '{3'd0, 2'd0, 5'd5,  1'b1, 32'h0000_0000, 32'h0000_002A, 32'h0000_002A, 1'b1};
    vecs[1]  = '{3'd0, 2'd3, 5'd0,  1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[2]  = '{3'd3, 2'd0, 5'd7,  1'b1, 32'h0000_0100, 32'h0000_0000, 32'hDEAD_BEEF, 1'b1};
    vecs[3]  = '{3'd2, 2'd0, 5'd8,  1'b1, 32'h0000_0102, 32'h0000_0000, 32'hFFFF_DEAD, 1'b1};
    vecs[4]  = '{3'd5, 2'd0, 5'd9,  1'b1, 32'h0000_0100, 32'h0000_0000, 32'h0000_BEEF, 1'b1};
    vecs[5]  = '{3'd0, 2'd1, 5'd1,  1'b1, 32'h0000_0103, 32'h1234_5680, 32'h0000_0000, 1'b0};
    vecs[6]  = '{3'd0, 2'd0, 5'd3,  1'b1, 32'h0000_0000, 32'h0000_0077, 32'h0000_0077, 1'b1};
    vecs[7]  = '{3'd1, 2'd0, 5'd10, 1'b1, 32'h0000_0103, 32'h0000_0000, 32'hFFFF_FF80, 1'b1};
    vecs[8]  = '{3'd4, 2'd0, 5'd11, 1'b1, 32'h0000_0103, 32'h0000_0000, 32'h0000_0080, 1'b1};
    vecs[9]  = '{3'd3, 2'd0, 5'd12, 1'b1, 32'h0000_0100, 32'h0000_0000, 32'h80AD_BEEF, 1'b1};
    vecs[10] = '{3'd0, 2'd2, 5'd2,  1'b0, 32'h0001_FFFF, 32'hABCD_1234, 32'h0000_0000, 1'b0};
    vecs[11] = '{3'd2, 2'd0, 5'd13, 1'b1, 32'h0001_FFFF, 32'h0000_0000, 32'h0000_1234, 1'b1};
    vecs[12] = '{3'd3, 2'd3, 5'd14, 1'b1, 32'h0000_0200, 32'h0102_0304, 32'h0000_0000, 1'b0};
    vecs[13] = '{3'd3, 2'd0, 5'd15, 1'b1, 32'h0000_0200, 32'h0000_0000, 32'h0102_0304, 1'b1};
    vecs[14] = '{3'd6, 2'd0, 5'd4,  1'b0, 32'h0000_0300, 32'h0000_0055, 32'h0000_0055, 1'b0};
    vecs[15] = '{3'd7, 2'd0, 5'd31, 1'b1, 32'h0000_0304, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1};

    #1 rst_n = 1'b0;
    #1 chk_reset_outputs("init_reset");
    repeat (2) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();
    tick();

    for (int i = 0; i < 16; i++) issue(vecs[i], $sformatf("v%0d", i));
    repeat (4) tick();
    chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
    chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);

    // Reset in the middle of an LW, with the request still held.
    mon_en          = 1'b0;
    bus.read_i      = 3'd3;
    bus.write_i     = 2'd0;
    bus.wd_i        = 5'd6;
    bus.wreg_i      = 1'b1;
    bus.addr_i      = 32'h0000_0100;
    bus.req_valid_i = 1'b1;
    tick();
    tick();
    chk("pre_reset_xfer_addr", 32'(bus.mem_addr_o), 32'h0000_0101);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("mid_reset");
    tick();
    chk_reset_outputs("held_reset");
    bus.req_valid_i = 1'b0;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_reset_no_wb", 32'(bus.wb_valid_o), 32'd0);
    end

    pv = '{3'd0, 2'd0, 5'd9, 1'b1, 32'h0, 32'h1357_9BDF, 32'h1357_9BDF, 1'b1};
    issue(pv, "post_reset_pass");
    repeat (3) tick();
    chk("final_wb_queue", 32'(wb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
